// File: rtl/stereolbm_mul_share_arbiter.sv
// Round-robin arbiter that shares one pipelined signed multiplier among NUM_REQ requesters.
// The optional macro STEREOLBM_MUL_ARB_PRIO0_EN gives requester 0 strict priority over the rest.
module stereolbm_mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int A_WIDTH     = 34,
  parameter int B_WIDTH     = 32,
  parameter int P_WIDTH     = 52,
  parameter int MUL_LATENCY = 1,
  parameter int ID_WIDTH    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         mul_ce,
  output logic [A_WIDTH-1:0]           mul_din0,
  output logic [B_WIDTH-1:0]           mul_din1,
  input  logic [P_WIDTH-1:0]           mul_dout,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic [P_WIDTH-1:0]           res_data,
  output logic                         busy
);

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] last_sel;
  logic [MUL_LATENCY-1:0] vld_pipe;
  logic [ID_WIDTH-1:0] id_pipe [MUL_LATENCY];

  logic                cand_found;
  logic [ID_WIDTH-1:0] cand;
  logic [ID_WIDTH-1:0] sel;
  logic                issue;

  assign res_valid = vld_pipe[MUL_LATENCY-1];
  assign res_id    = id_pipe[MUL_LATENCY-1];
  assign res_data  = mul_dout;
  assign busy      = |vld_pipe;
  assign mul_ce    = ~(res_valid & ~res_ready);
  assign issue     = cand_found & mul_ce & ~reset;

  always_comb begin
    int idx;
    int base;
    idx        = 0;
    base       = 0;
    cand_found = 1'b0;
    cand       = '0;
`ifdef STEREOLBM_MUL_ARB_PRIO0_EN
    if (req_valid[0]) begin
      cand_found = 1'b1;
      cand       = '0;
    end else begin
      // rr_ptr only ever points at 1..NUM_REQ-1 here; 0 (reset / wrap) means start at 1
      base = (rr_ptr == '0) ? 1 : int'(rr_ptr);
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        idx = 1 + ((base - 1 + k) % (NUM_REQ - 1));
        if (!cand_found && req_valid[idx]) begin
          cand_found = 1'b1;
          cand       = ID_WIDTH'(idx);
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!cand_found && req_valid[idx]) begin
        cand_found = 1'b1;
        cand       = ID_WIDTH'(idx);
      end
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[cand] = 1'b1;
  end

  assign sel = cand_found ? cand : last_sel;

  always_comb begin
    int s;
    s        = int'(sel);
    mul_din0 = req_a[s*A_WIDTH +: A_WIDTH];
    mul_din1 = req_b[s*B_WIDTH +: B_WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      last_sel <= '0;
      vld_pipe <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) id_pipe[i] <= '0;
    end else if (mul_ce) begin
      for (int i = MUL_LATENCY - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
      vld_pipe[0] <= issue;
      if (issue) begin
        id_pipe[0] <= cand;
        last_sel   <= cand;
`ifdef STEREOLBM_MUL_ARB_PRIO0_EN
        if (cand != '0) rr_ptr <= ID_WIDTH'((int'(cand) + 1) % NUM_REQ);
`else
        rr_ptr <= ID_WIDTH'((int'(cand) + 1) % NUM_REQ);
`endif
      end
    end
  end

endmodule

// File: tb/tb_stereolbm_mul_share_arbiter.sv
// Directed bench for stereolbm_mul_share_arbiter with a behavioural one-stage multiplier.
// Scenarios for STEREOLBM_MUL_ARB_PRIO0_EN are selected by the same macro.
module tb_stereolbm_mul_share_arbiter;
  localparam int N = 4, AW = 34, BW = 32, PW = 52, IW = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic mul_ce;
  logic [AW-1:0] mul_din0;
  logic [BW-1:0] mul_din1;
  logic [PW-1:0] mul_dout = '0;
  logic res_valid, res_ready = 1'b1;
  logic [IW-1:0] res_id;
  logic [PW-1:0] res_data;
  logic busy;

  logic [AW-1:0] a_op [N];
  logic [BW-1:0] b_op [N];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = a_op[i];
      req_b[i*BW +: BW] = b_op[i];
    end
  end

  // multiplier model: sign-extend, multiply, truncate, one register stage with ce
  logic signed [65:0] ea, eb, prod;
  assign ea = $signed(mul_din0);
  assign eb = $signed(mul_din1);
  assign prod = ea * eb;
  always_ff @(posedge clk) if (mul_ce) mul_dout <= prod[PW-1:0];

  stereolbm_mul_share_arbiter #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW),
                                .MUL_LATENCY(1), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_ce(mul_ce), .mul_din0(mul_din0),
    .mul_din1(mul_din1), .mul_dout(mul_dout), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_data(res_data), .busy(busy));

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; res_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = '0; end
    reset = 1'b1;
    #12;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || mul_ce !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: res_valid=%b busy=%b req_ready=%b mul_ce=%b want 0 0 0000 1",
               res_valid, busy, req_ready, mul_ce);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [PW-1:0] exp_p;
    exp_p = -52'sd15;
    @(negedge clk);
    a_op[2] = -34'sd3; b_op[2] = 32'sd5; req_valid = 4'b0100; res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant: req_ready=%b want 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== exp_p || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_result: valid=%b id=%0d data=%h busy=%b want 1 2 %h 1",
               res_valid, res_id, res_data, busy, exp_p);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_drain: valid=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    logic [PW-1:0] exp_p;
    do_reset();
    for (int i = 0; i < N; i++) begin a_op[i] = AW'(i + 1); b_op[i] = 32'd10; end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      exp_p   = PW'(10 * (k % 4 + 1));
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_grant[%0d]: req_ready=%b want %b", k, req_ready, exp_rdy);
      end
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_id !== IW'(k % 4) || res_data !== exp_p) begin
        errors++;
        $display("FAIL rr_result[%0d]: valid=%b id=%0d data=%0d want 1 %0d %0d",
                 k, res_valid, res_id, res_data, k % 4, exp_p);
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    logic [PW-1:0] exp_p;
    exp_p = -52'sd42;
    do_reset();
    a_op[1] = 34'sd7; b_op[1] = -32'sd6; a_op[3] = 34'sd4; b_op[3] = 32'sd9;
    req_valid = 4'b0010;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== exp_p) begin
      errors++; $display("FAIL stall_first: valid=%b id=%0d data=%h want 1 1 %h",
                         res_valid, res_id, res_data, exp_p);
    end
    @(negedge clk);
    req_valid = 4'b1000; res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (mul_ce !== 1'b0 || req_ready !== '0 || res_valid !== 1'b1 ||
          res_id !== 2'd1 || res_data !== exp_p) begin
        errors++;
        $display("FAIL stall_hold[%0d]: ce=%b rdy=%b valid=%b id=%0d data=%h want 0 0000 1 1 %h",
                 c, mul_ce, req_ready, res_valid, res_id, res_data, exp_p);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (mul_ce !== 1'b1 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL stall_release: ce=%b rdy=%b want 1 1000", mul_ce, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 52'd36) begin
      errors++; $display("FAIL stall_next: valid=%b id=%0d data=%0d want 1 3 36",
                         res_valid, res_id, res_data);
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_drain: valid=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_extreme();
    @(negedge clk);
    a_op[0] = {1'b1, 33'b0}; b_op[0] = {1'b1, 31'b0}; req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 52'd0) begin
      errors++; $display("FAIL extreme: valid=%b id=%0d data=%h want 1 0 0",
                         res_valid, res_id, res_data);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    a_op[0] = 34'sd2; b_op[0] = 32'sd3; req_valid = 4'b0001; res_ready = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_mid: valid=%b busy=%b rdy=%b want 0 0 0000",
                         res_valid, busy, req_ready);
    end
    @(negedge clk);
    reset = 1'b0; res_ready = 1'b1;
    a_op[3] = 34'sd5; b_op[3] = 32'sd5; req_valid = 4'b1000;
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 52'd25) begin
      errors++; $display("FAIL reset_post: valid=%b id=%0d data=%0d want 1 3 25",
                         res_valid, res_id, res_data);
    end
  endtask

`ifdef STEREOLBM_MUL_ARB_PRIO0_EN
  task automatic test_prio();
    do_reset();
    a_op[0] = 34'sd1; b_op[0] = 32'sd2; a_op[1] = 34'sd3; b_op[1] = 32'sd2;
    req_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
        errors++; $display("FAIL prio_grant[%0d]: rdy=%b want 0001", k, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL prio_fallback: rdy=%b want 0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (res_id !== 2'd1 || res_data !== 52'd6) begin
      errors++; $display("FAIL prio_result: id=%0d data=%0d want 1 6", res_id, res_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
`ifdef STEREOLBM_MUL_ARB_PRIO0_EN
    test_prio();
`else
    test_round_robin();
`endif
    test_stall();
    test_extreme();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stereolbm_mul_share_arbiter.md
Name: stereolbm_mul_share_arbiter

Overview:
Shares one pipelined signed multiplier (34s x 32s -> 52, one output register, clock-enable gated) among NUM_REQ requesters in the stereo LBM datapath. Requests are arbitrated round-robin, and each issue is tagged with the requester ID. The tag travels alongside the multiplier pipeline and is returned with the product on a single result bus. Result back-pressure stalls the whole multiplier pipeline through its ce input.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
A_WIDTH, 34, signed operand A width (multiplier din0)
B_WIDTH, 32, signed operand B width (multiplier din1)
P_WIDTH, 52, product width (multiplier dout)
MUL_LATENCY, 1, multiplier register stages between din and dout while ce=1
ID_WIDTH, 2, requester ID width; must be >= clog2(NUM_REQ)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester grant; handshake completes on valid&ready
req_a  in  NUM_REQ*A_WIDTH  packed signed A operands; requester i occupies bits [i*A_WIDTH +: A_WIDTH]
req_b  in  NUM_REQ*B_WIDTH  packed signed B operands, packed the same way
mul_ce  out  1  multiplier clock enable
mul_din0  out  A_WIDTH  operand A to multiplier
mul_din1  out  B_WIDTH  operand B to multiplier
mul_dout  in  P_WIDTH  product from multiplier
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_id  out  ID_WIDTH  requester ID of the current result
res_data  out  P_WIDTH  product; equals mul_dout
busy  out  1  high while any issued operation has not yet been delivered

Behaviour:
- Single clock domain. Reset is asynchronous, active-high. On reset:
  - rr_ptr=0, vld_pipe=0, id_pipe=0.
  - res_valid=0, req_ready=0, busy=0.
  - mul_ce=1 (no result is pending).
- Stall: mul_ce = ~(res_valid & ~res_ready). This signal is combinational.
- Pipeline tracking:
  - vld_pipe and id_pipe are MUL_LATENCY deep and shift only when mul_ce=1.
  - res_valid = vld_pipe[last]; res_id = id_pipe[last].
  - The multiplier holds dout while ce=0, so res_data = mul_dout stays stable during a stall.
- Arbitration (combinational in cycle t):
  - Candidate = first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - req_ready is one-hot on the candidate only when mul_ce=1. Otherwise req_ready=0.
- Issue (when any req_valid=1 and mul_ce=1):
  - mul_din0/mul_din1 = the candidate's operands.
  - vld_pipe[0] <= 1, id_pipe[0] <= candidate.
  - rr_ptr <= (candidate+1) mod NUM_REQ.
- Bubble (no valid request and mul_ce=1): vld_pipe[0] <= 0 and rr_ptr holds. mul_din0/mul_din1 are driven with the last granted operands, value don't-care.
- Latency: a request accepted at edge t produces res_valid=1 at edge t+MUL_LATENCY, provided no stall occurs in between. Each stall cycle adds exactly one cycle.
- Throughput: one issue per cycle with no bubbles while res_ready=1.
- Results leave in issue order. No result is dropped or duplicated under any res_ready pattern.
- Simultaneous result acceptance and new issue in the same cycle is allowed. res_valid&res_ready implies mul_ce=1.
- busy = |vld_pipe.
- Reset mid-operation: in-flight results are discarded (vld_pipe cleared). The multiplier output register is not reset; this is harmless because res_valid gates it.
- Width rules:
  - Operands pass through unmodified.
  - Sign-extension and truncation to P_WIDTH are done inside the multiplier.
  - The arbiter never alters res_data.
- A requester that drops req_valid without a handshake loses nothing; operands are sampled only on handshake.

Optional Feature:
STEREOLBM_MUL_ARB_PRIO0_EN:
- Defined: requester 0 has strict priority. If req_valid[0]=1 it is always the candidate, and rr_ptr does not advance on its grants. Requesters 1..NUM_REQ-1 rotate round-robin among themselves.
- Undefined: pure round-robin over all requesters, as described above.

Test Plan:
1. Reset asserted mid-stream with 1 result in flight -> res_valid=0, busy=0, req_ready=0 immediately (asynchronously). After release, the first result returned belongs to a post-reset issue.
2. Single request on req 2: A=-3, B=5, res_ready=1 -> one cycle later res_valid=1, res_id=2, res_data=-15 (52-bit sign-extended).
3. All 4 requesters continuously valid, A=i+1, B=10, res_ready=1 -> grants 0,1,2,3,0… on consecutive cycles; res_id follows the same sequence 1 cycle later; products 10,20,30,40.
4. res_ready held 0 for 3 cycles with a result pending -> mul_ce=0 and req_ready=0 for those 3 cycles; res_data/res_id stay stable; the next result follows immediately after release.
5. A=-2^33, B=-2^31 -> res_data = 2^64 truncated to 52 bits = 0 (sign and width handling delegated to the multiplier); res_valid=1.
6. With STEREOLBM_MUL_ARB_PRIO0_EN, req0 and req1 both continuously valid -> req0 granted every cycle and req1 starved. Drop req0 -> req1 granted on the next cycle.
